// File: rtl/act_pkg.sv
// act_pkg: shared types and constants for the activation stage.
//   act_mode_e     activation mode carried with every beat
//   ACT_MODE_W     width of the mode field
//   ACT_SAT_CNT_W  width of the saturation event counter
package act_pkg;

   localparam int ACT_MODE_W    = 2;
   localparam int ACT_SAT_CNT_W = 16;

   typedef enum logic [ACT_MODE_W-1:0] {
      ACT_BYPASS = 2'b00,
      ACT_RELU   = 2'b01,
      ACT_LEAKY  = 2'b10,
      ACT_CLAMP  = 2'b11
   } act_mode_e;

endpackage

// File: rtl/act_lane.sv
// act_lane: one-lane activation datapath, two register stages.
//   S1 captures the operand, mode, clamp ceiling, the full-width leak product
//   and the sign/compare flags. S2 rounds, saturates and selects the result.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   s1_ld, s2_ld   stage load strobes from the handshake control
//   en             lane enable of the incoming beat
//   x              signed operand
//   mode           activation mode of the incoming beat
//   leak, clamp_hi signed Q(DATA_W-FRAC_W).FRAC_W leak factor / clamp ceiling
//   y, y_en        registered result and its lane enable
//   sat            result was saturated (LEAKY overflow on an enabled lane)
module act_lane
   import act_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s1_ld,
   input  logic              s2_ld,
   input  logic              en,
   input  logic [DATA_W-1:0] x,
   input  act_mode_e         mode,
   input  logic [DATA_W-1:0] leak,
   input  logic [DATA_W-1:0] clamp_hi,
   output logic [DATA_W-1:0] y,
   output logic              y_en,
   output logic              sat
);

   localparam int PW = 2*DATA_W;
   localparam logic signed [PW-1:0]   RND  = signed'(PW'(1) << (FRAC_W-1));
   localparam logic [DATA_W-1:0]      MAXV = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0]      MINV = {1'b1, {(DATA_W-1){1'b0}}};

   logic signed [DATA_W-1:0] x_s;
   logic signed [DATA_W-1:0] leak_s;
   logic signed [DATA_W-1:0] hi_s;
   logic signed [PW-1:0]     prod_c;

   assign x_s    = signed'(x);
   assign leak_s = signed'(leak);
   assign hi_s   = signed'(clamp_hi);
   assign prod_c = PW'(x_s) * PW'(leak_s);

   logic                 s1_en;
   act_mode_e            s1_mode;
   logic [DATA_W-1:0]    s1_x;
   logic [DATA_W-1:0]    s1_hi;
   logic signed [PW-1:0] s1_prod;
   logic                 s1_neg;
   logic                 s1_hi_neg;
   logic                 s1_gt_hi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_en     <= 1'b0;
         s1_mode   <= ACT_BYPASS;
         s1_x      <= '0;
         s1_hi     <= '0;
         s1_prod   <= '0;
         s1_neg    <= 1'b0;
         s1_hi_neg <= 1'b0;
         s1_gt_hi  <= 1'b0;
      end else if (s1_ld) begin
         s1_en     <= en;
         s1_mode   <= mode;
         s1_x      <= x;
         s1_hi     <= clamp_hi;
         s1_prod   <= prod_c;
         s1_neg    <= x[DATA_W-1];
         s1_hi_neg <= clamp_hi[DATA_W-1];
         s1_gt_hi  <= (x_s > hi_s);
      end
   end

   // Rounded product; it fits DATA_W bits only if every bit from the sign
   // bit of the narrow result upward is identical.
   logic signed [PW-1:0]   sum_c;
   logic signed [PW-1:0]   shf_c;
   logic [PW-DATA_W:0]     top_c;
   logic                   ovf_c;
   logic [DATA_W-1:0]      res_c;
   logic                   sat_c;

   assign sum_c = s1_prod + RND;
   assign shf_c = sum_c >>> FRAC_W;
   assign top_c = shf_c[PW-1:DATA_W-1];
   assign ovf_c = !((&top_c) | ~(|top_c));

   always_comb begin
      res_c = '0;
      sat_c = 1'b0;
      if (s1_en) begin
         case (s1_mode)
            ACT_BYPASS: res_c = s1_x;
            ACT_RELU:   res_c = s1_neg ? '0 : s1_x;
            ACT_LEAKY: begin
               if (!s1_neg) begin
                  res_c = s1_x;
               end else if (ovf_c) begin
                  res_c = shf_c[PW-1] ? MINV : MAXV;
                  sat_c = 1'b1;
               end else begin
                  res_c = shf_c[DATA_W-1:0];
               end
            end
            ACT_CLAMP: begin
               // A negative operand or ceiling collapses to zero.
               if (s1_neg || s1_hi_neg) res_c = '0;
               else if (s1_gt_hi)       res_c = s1_hi;
               else                     res_c = s1_x;
            end
            default: res_c = s1_x;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y    <= '0;
         y_en <= 1'b0;
         sat  <= 1'b0;
      end else if (s2_ld) begin
         y    <= res_c;
         y_en <= s1_en;
         sat  <= sat_c;
      end
   end

endmodule

// File: rtl/act_unit.sv
// act_unit: N-lane pipelined activation stage (bypass / ReLU / leaky ReLU /
// clamped ReLU) with valid/ready handshake and backpressure.
// Optional feature macro: ACT_SAT_CNT_EN adds sat_cnt / sat_cnt_clr.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid, in_ready          input handshake
//   in_lane_en, in_data         per-lane enables and signed data of the beat
//   in_mode, in_leak,
//   in_clamp_hi                 per-beat activation settings
//   out_valid, out_ready        output handshake
//   out_lane_en, out_data       lane enables and results of the output beat
//   sat_cnt, sat_cnt_clr        saturation event count / clear (macro only)
module act_unit
   import act_pkg::*;
#(
   parameter int N      = 4,
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N-1:0]          in_lane_en,
   input  logic [N*DATA_W-1:0]   in_data,
   input  logic [ACT_MODE_W-1:0] in_mode,
   input  logic [DATA_W-1:0]     in_leak,
   input  logic [DATA_W-1:0]     in_clamp_hi,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [N-1:0]          out_lane_en,
   output logic [N*DATA_W-1:0]   out_data
`ifdef ACT_SAT_CNT_EN
   ,
   output logic [ACT_SAT_CNT_W-1:0] sat_cnt,
   input  logic                     sat_cnt_clr
`endif
);

   logic s1_valid;
   logic s2_valid;
   logic s1_adv;
   logic s2_adv;
   logic s1_ld;
   logic s2_ld;

   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign s1_ld     = in_valid && s1_adv;
   assign s2_ld     = s1_valid && s2_adv;
   assign out_valid = s2_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (s1_adv) s1_valid <= in_valid;
         if (s2_adv) s2_valid <= s1_valid;
      end
   end

   act_mode_e    mode_in;
   logic [N-1:0] lane_sat;

   assign mode_in = act_mode_e'(in_mode);

   for (genvar i = 0; i < N; i++) begin : g_lane
      act_lane #(
         .DATA_W (DATA_W),
         .FRAC_W (FRAC_W)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .s1_ld    (s1_ld),
         .s2_ld    (s2_ld),
         .en       (in_lane_en[i]),
         .x        (in_data[i*DATA_W +: DATA_W]),
         .mode     (mode_in),
         .leak     (in_leak),
         .clamp_hi (in_clamp_hi),
         .y        (out_data[i*DATA_W +: DATA_W]),
         .y_en     (out_lane_en[i]),
         .sat      (lane_sat[i])
      );
   end

`ifdef ACT_SAT_CNT_EN
   localparam int SUM_W = $clog2(N+1);

   logic [SUM_W-1:0]         sat_sum;
   logic [ACT_SAT_CNT_W:0]   cnt_next;

   always_comb begin
      sat_sum = '0;
      for (int i = 0; i < N; i++) begin
         sat_sum = sat_sum + SUM_W'(lane_sat[i]);
      end
   end

   assign cnt_next = {1'b0, sat_cnt} + (ACT_SAT_CNT_W+1)'(sat_sum);

   // Events are counted once per consumed beat, so a stalled beat is not
   // counted repeatedly. Clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_cnt <= '0;
      end else if (sat_cnt_clr) begin
         sat_cnt <= '0;
      end else if (out_valid && out_ready) begin
         sat_cnt <= cnt_next[ACT_SAT_CNT_W] ? '1 : cnt_next[ACT_SAT_CNT_W-1:0];
      end
   end
`else
   logic unused_sat;
   assign unused_sat = ^lane_sat;
`endif

endmodule

// File: tb/tb_act_unit.sv
module tb_act_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_lane_en;
   logic [63:0] in_data;
   logic [1:0]  in_mode;
   logic [15:0] in_leak;
   logic [15:0] in_clamp_hi;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_lane_en;
   logic [63:0] out_data;
   logic [15:0] sat_cnt;
   logic        sat_cnt_clr;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   act_unit #(.N(4), .DATA_W(16), .FRAC_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_lane_en  (in_lane_en),
      .in_data     (in_data),
      .in_mode     (in_mode),
      .in_leak     (in_leak),
      .in_clamp_hi (in_clamp_hi),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_lane_en (out_lane_en),
      .out_data    (out_data)
`ifdef ACT_SAT_CNT_EN
      ,
      .sat_cnt     (sat_cnt),
      .sat_cnt_clr (sat_cnt_clr)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated beat with out_ready high; checks latency, data and enables.
   task automatic send_one(input string tag, input logic [1:0] m, input logic [15:0] lk,
                           input logic [15:0] ch, input logic [3:0] en,
                           input logic [63:0] d, input logic [63:0] e);
      int lat;
      in_valid    = 1'b1;
      in_mode     = m;
      in_leak     = lk;
      in_clamp_hi = ch;
      in_lane_en  = en;
      in_data     = d;
      out_ready   = 1'b1;
      tick();
      // Scramble settings so a beat in flight that re-reads them would differ.
      in_valid    = 1'b0;
      in_mode     = ~m;
      in_leak     = ~lk;
      in_clamp_hi = ~ch;
      in_lane_en  = ~en;
      in_data     = ~d;
      lat = 1;
      while (!out_valid && lat < 10) begin
         tick();
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'd2);
      chk({tag, "_data"}, out_data, e);
      chk({tag, "_en"}, 64'(out_lane_en), 64'(en));
      tick();
   endtask

   logic [63:0] s_din [8];
   logic [63:0] s_exp [8];
   logic [1:0]  s_mode [8];
   logic [15:0] s_leak [8];
   logic [15:0] s_clamp [8];

   task automatic set_beat(input int i, input logic [1:0] m, input logic [15:0] x0,
                           input logic [15:0] x2, input logic [15:0] e0, input logic [15:0] e2);
      s_din[i]   = {16'h7777, x2, 16'h7777, x0};
      s_exp[i]   = {16'h0000, e2, 16'h0000, e0};
      s_mode[i]  = m;
      s_leak[i]  = (m == 2'b10) ? 16'h0080 : 16'h7FFF;
      s_clamp[i] = (m == 2'b11) ? 16'h0100 : 16'hFF00;
   endtask

   initial begin
      int          sent;
      int          recv;
      int          occ;
      logic        acc;
      logic        cons;
      logic        prev_stall;
      logic [63:0] prev_data;
      logic [3:0]  rdy_pat;
      logic        seen;

      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_lane_en  = '0;
      in_data     = '0;
      in_mode     = '0;
      in_leak     = '0;
      in_clamp_hi = '0;
      out_ready   = 1'b0;
      sat_cnt_clr = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_out_en", 64'(out_lane_en), 64'd0);
`ifdef ACT_SAT_CNT_EN
      chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
`endif
      rst_n = 1'b1;
      tick();
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // Directed single beats: {lane3, lane2, lane1, lane0}
      send_one("leak_q25", 2'b10, 16'h0040, 16'h0, 4'hF,
               {16'hFFFF, 16'h0000, 16'h0100, 16'hFF00},
               {16'h0000, 16'h0000, 16'h0100, 16'hFFC0});
      send_one("leak_rnd", 2'b10, 16'h0080, 16'h0, 4'hF,
               {16'hFFFF, 16'hFFFC, 16'h0005, 16'hFFFD},
               {16'h0000, 16'hFFFE, 16'h0005, 16'hFFFF});
      send_one("leak_sat_lo", 2'b10, 16'h7FFF, 16'h0, 4'hF,
               {16'hFF00, 16'h0002, 16'h0001, 16'h8000},
               {16'h8001, 16'h0002, 16'h0001, 16'h8000});
`ifdef ACT_SAT_CNT_EN
      chk("sat_cnt_one", 64'(sat_cnt), 64'd1);
      sat_cnt_clr = 1'b1;
      send_one("leak_sat_clr", 2'b10, 16'h7FFF, 16'h0, 4'hF,
               {16'hFF00, 16'h0002, 16'h0001, 16'h8000},
               {16'h8001, 16'h0002, 16'h0001, 16'h8000});
      chk("sat_cnt_clr_prio", 64'(sat_cnt), 64'd0);
      sat_cnt_clr = 1'b0;
`endif
      send_one("leak_sat_hi", 2'b10, 16'h8000, 16'h0, 4'hF,
               {16'h7FFF, 16'h0000, 16'hFFFF, 16'h8000},
               {16'h7FFF, 16'h0000, 16'h0080, 16'h7FFF});
`ifdef ACT_SAT_CNT_EN
      chk("sat_cnt_pos", 64'(sat_cnt), 64'd1);
`endif
      send_one("clamp", 2'b11, 16'h0, 16'h0600, 4'hF,
               {16'h0500, 16'h0600, 16'hFF00, 16'h0700},
               {16'h0500, 16'h0600, 16'h0000, 16'h0600});
      send_one("clamp_neg_hi", 2'b11, 16'h0, 16'hFF00, 4'hF,
               {16'h7FFF, 16'h0000, 16'hFF80, 16'h0100},
               64'h0);
      send_one("relu", 2'b01, 16'h0, 16'h0, 4'hF,
               {16'h7FFF, 16'h8000, 16'h0100, 16'hFF00},
               {16'h7FFF, 16'h0000, 16'h0100, 16'h0000});
      send_one("bypass", 2'b00, 16'h0, 16'h0, 4'hF,
               {16'h0000, 16'hFFFF, 16'h1234, 16'h8001},
               {16'h0000, 16'hFFFF, 16'h1234, 16'h8001});
      send_one("lane_dis", 2'b10, 16'h7FFF, 16'h0, 4'b0101,
               {16'h8000, 16'h8000, 16'h8000, 16'h8000},
               {16'h0000, 16'h8000, 16'h0000, 16'h8000});
`ifdef ACT_SAT_CNT_EN
      chk("sat_cnt_lane_en", 64'(sat_cnt), 64'd3);
`endif

      // Stream with modes changing every beat and lanes 1/3 disabled.
      set_beat(0, 2'b00, 16'hFF00, 16'h0123, 16'hFF00, 16'h0123);
      set_beat(1, 2'b01, 16'hFF00, 16'h0123, 16'h0000, 16'h0123);
      set_beat(2, 2'b10, 16'hFF00, 16'h0123, 16'hFF80, 16'h0123);
      set_beat(3, 2'b11, 16'hFF00, 16'h0123, 16'h0000, 16'h0100);
      set_beat(4, 2'b00, 16'h8000, 16'h0050, 16'h8000, 16'h0050);
      set_beat(5, 2'b01, 16'h8000, 16'h0050, 16'h0000, 16'h0050);
      set_beat(6, 2'b10, 16'h8000, 16'h0050, 16'hC000, 16'h0050);
      set_beat(7, 2'b11, 16'h8000, 16'h0050, 16'h0000, 16'h0050);

      rdy_pat    = 4'b1001;
      sent       = 0;
      recv       = 0;
      occ        = 0;
      prev_stall = 1'b0;
      prev_data  = '0;
      in_lane_en = 4'b0101;
      for (int cyc = 0; cyc < 100 && recv < 8; cyc++) begin
         out_ready = rdy_pat[cyc % 4];
         in_valid  = (sent < 8);
         if (sent < 8) begin
            in_data     = s_din[sent];
            in_mode     = s_mode[sent];
            in_leak     = s_leak[sent];
            in_clamp_hi = s_clamp[sent];
         end
         #1;
         chk("strm_in_ready", 64'(in_ready), 64'((occ < 2) || out_ready));
         if (prev_stall) chk("strm_hold", out_data, prev_data);
         if (out_valid) begin
            chk("strm_data", out_data, s_exp[recv]);
            chk("strm_en", 64'(out_lane_en), 64'(4'b0101));
         end
         acc        = in_valid && in_ready;
         cons       = out_valid && out_ready;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         tick();
         if (acc)  sent++;
         if (cons) recv++;
         occ = occ + int'(acc) - int'(cons);
      end
      chk("strm_count", 64'(recv), 64'd8);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();

      // Reset in the middle of a stream drops in-flight beats.
      for (int b = 0; b < 2; b++) begin
         in_valid    = 1'b1;
         in_data     = s_din[b];
         in_mode     = s_mode[b];
         in_leak     = s_leak[b];
         in_clamp_hi = s_clamp[b];
         tick();
      end
      chk("pre_rst_valid", 64'(out_valid), 64'd1);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_data", out_data, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", 64'(in_ready), 64'd1);
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         seen = seen | out_valid;
         tick();
      end
      chk("rst_no_stale", 64'(seen), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
